// File: rtl/snn_pkg.sv
`timescale 1ns/1ps
// snn_pkg: frame geometry and loader state encoding shared by the SNN core
// and its input loader.
package snn_pkg;

    localparam int         NUM_PIXELS = 784;
    localparam int         NUM_BYTES  = (NUM_PIXELS + 7) / 8;
    localparam int         ADDR_W     = 10;
    localparam logic [7:0] THRESH     = 8'h80;

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        UNPACK    = 2'd1,
        START     = 2'd2,
        WAIT_CORE = 2'd3
    } loader_state_t;

endpackage

// File: rtl/snn_input_loader_if.sv
`timescale 1ns/1ps
// snn_input_loader_if: UART byte stream in, core start/pixel-read/done
// handshake, and loader status. The loader sits on the slave side.
interface snn_input_loader_if;

    logic                        rx_rdy;
    logic [7:0]                  rx_data;
    logic [snn_pkg::ADDR_W-1:0]  addr_input_unit;
    logic                        core_done;
    logic                        q_input;
    logic                        start;
    logic                        busy;
    logic                        overrun;

    modport master (
        output rx_rdy, rx_data, addr_input_unit, core_done,
        input  q_input, start, busy, overrun
    );

    modport slave (
        input  rx_rdy, rx_data, addr_input_unit, core_done,
        output q_input, start, busy, overrun
    );

endinterface

// File: rtl/snn_input_loader_bit_ram.sv
`timescale 1ns/1ps
// bit_ram: 1-bit wide synchronous single-port RAM with registered read data.
// Reads beyond DEPTH return 0; rdata holds its value when re is low.
module bit_ram #(
    parameter int DEPTH = 784,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic          wdata,
    output logic          rdata
);

    logic mem [DEPTH];
    logic in_range;

    // address bound check shared by read and write
    always_comb begin
        in_range = int'(addr) < DEPTH;
    end

    // storage is never reset; contents are only meaningful after a full frame
    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[addr] <= wdata;
        end
    end

    // registered read port, out-of-range reads return 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= 1'b0;
        end else if (re) begin
            rdata <= in_range ? mem[addr] : 1'b0;
        end
    end

endmodule

// File: rtl/snn_input_loader.sv
`timescale 1ns/1ps
// snn_input_loader: buffers a binary image from the UART byte stream, starts
// the SNN core and serves its pixel reads until core_done.
// Build option: SNN_LOADER_THRESH_EN -> one grayscale byte per pixel,
// binarised against THRESH; otherwise 8 packed pixels per byte, LSB first.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// LOAD       | wait for a byte in the holding register, move it to shift
// UNPACK     | write one pixel per cycle from shift[0] into the buffer
// START      | one-cycle start pulse to the core, rewind pixel counter
// WAIT_CORE  | buffer read-only, serve core reads until core_done
module snn_input_loader
    import snn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    snn_input_loader_if.slave bus
);

    localparam logic [1:0]        ST_LOAD      = LOAD;
    localparam logic [1:0]        ST_UNPACK    = UNPACK;
    localparam logic [1:0]        ST_START     = START;
    localparam logic [1:0]        ST_WAIT_CORE = WAIT_CORE;
    localparam logic [ADDR_W-1:0] LAST_PIX     = ADDR_W'(NUM_PIXELS - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pix_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        hold_reg;
    logic              hold_full;
    logic [7:0]        shift_reg;
    logic              start_q;
    logic              busy_q;
    logic              overrun_q;

    logic              accept_win;
    logic              consume;
    logic              capture;
    logic              drop;
    logic              frame_last;
    logic              byte_last;
    logic [7:0]        load_value;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;

    // holding-register arbitration: a byte consumed by LOAD frees the slot
    // for a byte arriving in the same cycle
    always_comb begin
        accept_win = (state == ST_LOAD) || (state == ST_UNPACK);
        consume    = (state == ST_LOAD) && hold_full;
        capture    = bus.rx_rdy && accept_win && (!hold_full || consume);
        drop       = bus.rx_rdy && accept_win && hold_full && !consume;
        frame_last = (pix_cnt == LAST_PIX);
    end

    // per-mode byte interpretation
    always_comb begin
        load_value = hold_reg;
        byte_last  = 1'b0;
`ifdef SNN_LOADER_THRESH_EN
        load_value = {7'd0, (hold_reg >= THRESH)};
        byte_last  = 1'b1;
`else
        load_value = hold_reg;
        byte_last  = (bit_cnt == 3'd7);
`endif
    end

    // single buffer port: writer during UNPACK, core reader otherwise
    always_comb begin
        ram_we   = (state == ST_UNPACK);
        ram_re   = (state == ST_WAIT_CORE);
        ram_addr = ram_we ? pix_cnt : bus.addr_input_unit;
    end

    // sequencing FSM with pixel/bit counters and the unpack shift register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_LOAD;
            pix_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            start_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (hold_full) begin
                        shift_reg <= load_value;
                        bit_cnt   <= '0;
                        state     <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    shift_reg <= {1'b0, shift_reg[7:1]};
                    pix_cnt   <= pix_cnt + ADDR_W'(1);
                    bit_cnt   <= bit_cnt + 3'd1;
                    if (frame_last) begin
                        start_q <= 1'b1;
                        state   <= ST_START;
                    end else if (byte_last) begin
                        state <= ST_LOAD;
                    end
                end
                ST_START: begin
                    pix_cnt <= '0;
                    bit_cnt <= '0;
                    state   <= ST_WAIT_CORE;
                end
                default: begin
                    if (bus.core_done) begin
                        state <= ST_LOAD;
                    end
                end
            endcase
        end
    end

    // holding register plus busy and sticky overrun flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (capture) begin
                hold_reg  <= bus.rx_data;
                hold_full <= 1'b1;
                busy_q    <= 1'b1;
            end else if (consume) begin
                hold_full <= 1'b0;
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end
            if ((state == ST_WAIT_CORE) && bus.core_done) begin
                busy_q <= 1'b0;
            end
        end
    end

    bit_ram #(
        .DEPTH (NUM_PIXELS),
        .AW    (ADDR_W)
    ) u_bit_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (shift_reg[0]),
        .rdata (bus.q_input)
    );

    assign bus.start   = start_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_snn_input_loader.sv
`timescale 1ns/1ps
// Directed bench for snn_input_loader: read-back tables per frame plus
// hand-written sequences for overrun, ignored traffic and mid-frame reset.
module tb_snn_input_loader;
    import snn_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snn_input_loader_if bus();

    snn_input_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int                grp;
        logic [ADDR_W-1:0] addr;
        logic              exp;
    } rd_vec_t;

    rd_vec_t tbl[$];
    int      n_checks = 0;
    int      n_errors = 0;
    int      start_count = 0;
    time     start_time = 0;
    time     drive_time = 0;

    // count start pulses and remember when the latest one was seen
    always @(negedge clk) begin
        if (bus.start === 1'b1) begin
            start_count++;
            start_time = $time;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        drive_time  = $time;
        @(negedge clk);
        bus.rx_rdy  = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_core_done();
        @(negedge clk);
        bus.core_done = 1'b1;
        @(negedge clk);
        bus.core_done = 1'b0;
    endtask

    task automatic apply_reads(input int grp);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].grp == grp) begin
                @(negedge clk);
                bus.addr_input_unit = tbl[i].addr;
                @(negedge clk);
                check($sformatf("q_input[%0d] grp%0d", tbl[i].addr, grp),
                      32'(bus.q_input), 32'(tbl[i].exp));
            end
        end
    endtask

    // expected pixel of a frame whose byte k is k ^ key
    function automatic logic px(input int a, input logic [7:0] key);
        logic [7:0] b;
        if (a >= NUM_PIXELS) return 1'b0;
        b = 8'(a / 8) ^ key;
        return b[a % 8];
    endfunction

    int addr_list[16] = '{0, 1, 2, 7, 8, 15, 16, 17, 100, 399, 400, 555, 782, 783, 784, 1023};
    int a_addr[12]    = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 13, 783, 800};
    logic a_exp[12]   = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 1, 0};
    int t_addr[9]     = '{0, 1, 2, 3, 500, 501, 782, 783, 800};

    initial begin
        bus.rx_rdy          = 1'b0;
        bus.rx_data         = 8'h00;
        bus.addr_input_unit = '0;
        bus.core_done       = 1'b0;
        rst_n               = 1'b0;

        for (int i = 0; i < 12; i++)
            tbl.push_back('{grp: 0, addr: ADDR_W'(a_addr[i]), exp: a_exp[i]});
        for (int i = 0; i < 16; i++) begin
            tbl.push_back('{grp: 1, addr: ADDR_W'(addr_list[i]), exp: px(addr_list[i], 8'h3C)});
            tbl.push_back('{grp: 2, addr: ADDR_W'(addr_list[i]), exp: px(addr_list[i], 8'hC3)});
        end
        for (int i = 0; i < 9; i++)
            tbl.push_back('{grp: 3, addr: ADDR_W'(t_addr[i]),
                            exp: (t_addr[i] < NUM_PIXELS) ? 1'(t_addr[i] % 2) : 1'b0});

        repeat (3) @(negedge clk);
        check("reset q_input", 32'(bus.q_input), 0);
        check("reset start", 32'(bus.start), 0);
        check("reset busy", 32'(bus.busy), 0);
        check("reset overrun", 32'(bus.overrun), 0);
        rst_n = 1'b1;

`ifndef SNN_LOADER_THRESH_EN
        // frame A: 98 x A5 with wide gaps
        for (int k = 0; k < NUM_BYTES; k++) send_byte(8'hA5, 20);
        check("A start count", 32'(start_count), 1);
        check("A start latency", 32'(start_time - drive_time), 100);
        check("A busy", 32'(bus.busy), 1);
        check("A overrun", 32'(bus.overrun), 0);
        apply_reads(0);

        // traffic during WAIT_CORE is ignored
        @(negedge clk);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        bus.rx_rdy  = 1'b0;
        repeat (12) @(negedge clk);
        check("wait rx overrun", 32'(bus.overrun), 0);
        check("wait rx busy", 32'(bus.busy), 1);
        check("wait rx start count", 32'(start_count), 1);
        apply_reads(0);
        pulse_core_done();
        check("busy after core_done", 32'(bus.busy), 0);

        // frame B: three back-to-back bytes, third one is lost
        @(negedge clk);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'h00 ^ 8'h3C;
        @(negedge clk);
        bus.rx_data = 8'h01 ^ 8'h3C;
        @(negedge clk);
        bus.rx_data = 8'hFF;
        @(negedge clk);
        bus.rx_rdy  = 1'b0;
        check("B overrun set", 32'(bus.overrun), 1);
        check("B busy", 32'(bus.busy), 1);
        repeat (20) @(negedge clk);
        pulse_core_done();
        check("core_done outside wait", 32'(bus.busy), 1);
        for (int k = 2; k < NUM_BYTES - 1; k++) send_byte(8'(k) ^ 8'h3C, 12);
        repeat (4) @(negedge clk);
        check("B no early start", 32'(start_count), 1);
        send_byte(8'(NUM_BYTES - 1) ^ 8'h3C, 12);
        check("B start count", 32'(start_count), 2);
        check("B start latency", 32'(start_time - drive_time), 100);
        check("B overrun sticky", 32'(bus.overrun), 1);
        apply_reads(1);
        pulse_core_done();
        check("B busy cleared", 32'(bus.busy), 0);

        // partial frame aborted by reset in the middle of an unpack
        for (int k = 0; k < 49; k++) send_byte(8'h00, 12);
        send_byte(8'h00, 3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort busy", 32'(bus.busy), 0);
        check("abort overrun", 32'(bus.overrun), 0);
        check("abort start", 32'(bus.start), 0);
        check("abort start count", 32'(start_count), 2);

        // frame C starts from pixel 0 again
        for (int k = 0; k < NUM_BYTES - 1; k++) send_byte(8'(k) ^ 8'hC3, 12);
        repeat (4) @(negedge clk);
        check("C no early start", 32'(start_count), 2);
        send_byte(8'(NUM_BYTES - 1) ^ 8'hC3, 12);
        check("C start count", 32'(start_count), 3);
        check("C start latency", 32'(start_time - drive_time), 100);
        apply_reads(2);
`else
        // grayscale frame alternating just below / at threshold
        for (int k = 0; k < NUM_PIXELS - 1; k++) send_byte((k % 2 == 1) ? 8'h80 : 8'h7F, 3);
        check("T no early start", 32'(start_count), 0);
        send_byte(8'h80, 3);
        check("T start count", 32'(start_count), 1);
        check("T start latency", 32'(start_time - drive_time), 30);
        check("T overrun", 32'(bus.overrun), 0);
        apply_reads(3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
